// File: rtl/frat_ckpt_ctrl.sv
// frat_ckpt_ctrl: FRAT branch-checkpoint slot sequencer.
// Allocates/frees snapshot slots and drives FRAT restore on mispredict.
module frat_ckpt_ctrl #(
    parameter int ISSUE_WIDTH   = 2,
    parameter int NUM_CKPT      = 4,
    parameter int ROB_SIZE_CLOG = 5,
    parameter int RECOV_CYC     = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [ISSUE_WIDTH-1:0]                   br_val_id,
    input  logic [ROB_SIZE_CLOG-1:0]                 rob_is_ptr,
    input  logic                                     br_ret_val,
    input  logic [ROB_SIZE_CLOG-1:0]                 br_ret_robid,
    input  logic                                     mispred_val,
    input  logic [ROB_SIZE_CLOG-1:0]                 mispred_robid,
    output logic [ISSUE_WIDTH-1:0]                   ckpt_we,
    output logic [ISSUE_WIDTH*$clog2(NUM_CKPT)-1:0]  ckpt_slot,
    output logic                                     restore_val,
    output logic [$clog2(NUM_CKPT)-1:0]              restore_slot,
    output logic                                     rename_stall,
    output logic [$clog2(NUM_CKPT):0]                ckpt_cnt,
    output logic                                     recov_err
);

    localparam int SW = $clog2(NUM_CKPT);
    localparam int CW = SW + 1;
    localparam int DW = (RECOV_CYC > 1) ? $clog2(RECOV_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RESTORE,
        DRAIN
    } state_t;

    state_t state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;

    logic [SW-1:0]            head_q, head_d;
    logic [SW-1:0]            tail_q, tail_d;
    logic [NUM_CKPT-1:0]      vld_q, vld_d;
    logic [ROB_SIZE_CLOG-1:0] robid_q [NUM_CKPT];
    logic [CW-1:0]            cnt_q, cnt_d;

    logic          idle;
    logic          ret_hit;
    logic          ret_err;
    logic          mp_hit;
    logic [SW-1:0] mp_slot;
    logic [CW-1:0] mp_age;
    logic          mp_take;
    logic          mp_err;
    logic [CW-1:0] k;
    logic [CW-1:0] free_slots;
    logic          alloc_ok;
    logic [SW-1:0] lane_slot [ISSUE_WIDTH];

    assign idle    = (state_q == IDLE);
    assign ret_hit = br_ret_val && vld_q[head_q]
                     && (robid_q[head_q] == br_ret_robid);
    assign ret_err = br_ret_val && !ret_hit;

    // Age-ordered CAM; the head slot retiring this cycle cannot match.
    always_comb begin : mp_search
        logic [SW-1:0] idx;
        idx     = '0;
        mp_hit  = 1'b0;
        mp_slot = '0;
        mp_age  = '0;
        for (int j = 0; j < NUM_CKPT; j++) begin
            idx = head_q + SW'(j);
            if (!mp_hit && vld_q[idx]
                && (robid_q[idx] == mispred_robid)
                && !(j == 0 && ret_hit)) begin
                mp_hit  = 1'b1;
                mp_slot = idx;
                mp_age  = CW'(j);
            end
        end
    end

    assign mp_take = idle && mispred_val && mp_hit;
    assign mp_err  = idle && mispred_val && !mp_hit;

    always_comb begin : lane_alloc
        logic [SW-1:0] off;
        off = '0;
        k   = '0;
        for (int n = 0; n < ISSUE_WIDTH; n++) begin
            lane_slot[n] = tail_q + off;
            if (br_val_id[n]) begin
                off = off + SW'(1);
                k   = k + CW'(1);
            end
        end
    end

    // Retire in the same cycle does not free room for this group.
    assign free_slots = CW'(NUM_CKPT) - cnt_q;
    assign alloc_ok   = idle && !mp_take && (k <= free_slots);

    always_comb begin
        ckpt_we   = alloc_ok ? br_val_id : '0;
        ckpt_slot = '0;
        for (int n = 0; n < ISSUE_WIDTH; n++) begin
            ckpt_slot[n*SW +: SW] = lane_slot[n];
        end
    end

    assign rename_stall = !idle || mp_take || (k > free_slots);
    assign ckpt_cnt     = cnt_q;

    always_comb begin : slot_next
        logic [SW-1:0] idx;
        idx    = '0;
        vld_d  = vld_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (ret_hit) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + SW'(1);
        end
        if (alloc_ok) begin
            for (int n = 0; n < ISSUE_WIDTH; n++) begin
                if (br_val_id[n]) begin
                    vld_d[lane_slot[n]] = 1'b1;
                end
            end
            tail_d = tail_q + SW'(k);
            cnt_d  = cnt_q + k - CW'(ret_hit);
        end else if (mp_take) begin
            for (int j = 0; j < NUM_CKPT; j++) begin
                idx = head_q + SW'(j);
                if (CW'(j) >= mp_age) begin
                    vld_d[idx] = 1'b0;
                end
            end
            tail_d = mp_slot;
            cnt_d  = mp_age - CW'(ret_hit);
        end else begin
            cnt_d = cnt_q - CW'(ret_hit);
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            IDLE: begin
                if (mp_take) begin
                    state_d = RESTORE;
                end
            end
            RESTORE: begin
                state_d = DRAIN;
                drain_d = DW'(RECOV_CYC - 1);
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            drain_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            vld_q        <= '0;
            cnt_q        <= '0;
            restore_val  <= 1'b0;
            restore_slot <= '0;
            recov_err    <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            vld_q       <= vld_d;
            cnt_q       <= cnt_d;
            restore_val <= mp_take;
            if (mp_take) begin
                restore_slot <= mp_slot;
            end
            if (ret_err || mp_err) begin
                recov_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int n = 0; n < ISSUE_WIDTH; n++) begin
            if (alloc_ok && br_val_id[n]) begin
                robid_q[lane_slot[n]] <= rob_is_ptr + ROB_SIZE_CLOG'(n);
            end
        end
    end

endmodule

// File: tb/tb_frat_ckpt_ctrl.sv
// tb_frat_ckpt_ctrl: directed + random checks of frat_ckpt_ctrl
// against a queue-based model of the checkpoint store.
module tb_frat_ckpt_ctrl;

    localparam int NCK = 4;
    localparam int RC  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_val_id;
    logic [4:0] rob_is_ptr;
    logic       br_ret_val;
    logic [4:0] br_ret_robid;
    logic       mispred_val;
    logic [4:0] mispred_robid;
    logic [1:0] ckpt_we;
    logic [3:0] ckpt_slot;
    logic       restore_val;
    logic [1:0] restore_slot;
    logic       rename_stall;
    logic [2:0] ckpt_cnt;
    logic       recov_err;

    always #5 clk = ~clk;

    frat_ckpt_ctrl #(
        .ISSUE_WIDTH  (2),
        .NUM_CKPT     (NCK),
        .ROB_SIZE_CLOG(5),
        .RECOV_CYC    (RC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .br_val_id    (br_val_id),
        .rob_is_ptr   (rob_is_ptr),
        .br_ret_val   (br_ret_val),
        .br_ret_robid (br_ret_robid),
        .mispred_val  (mispred_val),
        .mispred_robid(mispred_robid),
        .ckpt_we      (ckpt_we),
        .ckpt_slot    (ckpt_slot),
        .restore_val  (restore_val),
        .restore_slot (restore_slot),
        .rename_stall (rename_stall),
        .ckpt_cnt     (ckpt_cnt),
        .recov_err    (recov_err)
    );

    int errors = 0;
    int checks = 0;

    // Model: q holds live robids oldest first; slot = (head_m + age) % NCK.
    int q[$];
    int head_m   = 0;
    int rec_left = 0;
    int nr       = 0;
    int m_rs     = 0;
    bit m_rv     = 0;
    bit m_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        head_m   = 0;
        rec_left = 0;
        nr       = 0;
        m_rs     = 0;
        m_rv     = 0;
        m_err    = 0;
    endtask

    task automatic idle_inputs();
        br_val_id     = 2'b00;
        rob_is_ptr    = 5'd0;
        br_ret_val    = 1'b0;
        br_ret_robid  = 5'd0;
        mispred_val   = 1'b0;
        mispred_robid = 5'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic cyc(input logic [1:0] val, input int rptr,
                       input bit rv, input int rid,
                       input bit mv, input int mid);
        int sz, k, age, lower;
        bit idle, ret_ok, hit, alloc, e_stall;
        logic [1:0] e_we;
        @(negedge clk);
        br_val_id     = val;
        rob_is_ptr    = 5'(rptr);
        br_ret_val    = rv;
        br_ret_robid  = 5'(rid);
        mispred_val   = mv;
        mispred_robid = 5'(mid);
        #1;
        sz     = q.size();
        k      = int'(val[0]) + int'(val[1]);
        idle   = (rec_left == 0);
        ret_ok = rv && (sz > 0) && (q[0] == rid);
        hit    = 0;
        age    = 0;
        if (idle && mv) begin
            for (int a = 0; a < sz; a++) begin
                if (!hit && q[a] == mid && !(a == 0 && ret_ok)) begin
                    hit = 1;
                    age = a;
                end
            end
        end
        alloc   = idle && !hit && (k <= NCK - sz);
        e_we    = alloc ? val : 2'b00;
        e_stall = !idle || hit || (k > NCK - sz);
        chk("ckpt_we", ckpt_we, e_we);
        chk("rename_stall", rename_stall, e_stall);
        lower = 0;
        for (int n = 0; n < 2; n++) begin
            if (val[n]) begin
                if (e_we[n]) begin
                    chk($sformatf("ckpt_slot%0d", n), ckpt_slot[n*2 +: 2],
                        (head_m + sz + lower) % NCK);
                end
                lower++;
            end
        end
        chk("restore_val", restore_val, m_rv);
        if (m_rv) chk("restore_slot", restore_slot, m_rs);
        chk("ckpt_cnt", ckpt_cnt, sz);
        chk("recov_err", recov_err, m_err);

        if (rec_left > 0) rec_left--;
        if ((rv && !ret_ok) || (idle && mv && !hit)) m_err = 1;
        m_rv = hit;
        if (hit) begin
            m_rs = (head_m + age) % NCK;
            while (q.size() > age) void'(q.pop_back());
            rec_left = 1 + RC;
            nr = mid;
        end
        if (ret_ok) begin
            void'(q.pop_front());
            head_m = (head_m + 1) % NCK;
        end
        if (alloc) begin
            for (int n = 0; n < 2; n++) begin
                if (val[n]) q.push_back((rptr + n) % 32);
            end
            nr = (rptr + 2) % 32;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] v;
        bit r, m;
        int rid, mid, lo, miss;
        bit found;

        rst = 1'b1;
        idle_inputs();
        do_reset();

        // Reset state, then two-lane group into slots 0/1
        cyc(2'b00, 0, 0, 0, 0, 0);
        chk("rst_restore_slot", restore_slot, 0);
        cyc(2'b11, 5, 0, 0, 0, 0);
        cyc(2'b00, 0, 0, 0, 0, 0);

        // Fill toward full; oversize group is stalled whole
        cyc(2'b10, 8, 0, 0, 0, 0);
        cyc(2'b11, 10, 0, 0, 0, 0);
        cyc(2'b01, 12, 0, 0, 0, 0);
        cyc(2'b00, 0, 0, 0, 0, 0);
        chk("full_cnt", ckpt_cnt, 4);

        // Mispredict robid 9 -> restore slot 2, stall 4 cycles
        cyc(2'b00, 0, 0, 0, 1, 9);
        for (int i = 0; i < 1 + RC; i++) cyc(2'b01, 9, 0, 0, 0, 0);
        cyc(2'b01, 9, 0, 0, 0, 0);
        cyc(2'b01, 12, 0, 0, 0, 0);

        // Full: retire without credit, then alloc next cycle
        cyc(2'b01, 13, 1, 5, 0, 0);
        cyc(2'b01, 13, 0, 0, 0, 0);

        // Wrap: alloc+retire pairs
        cyc(2'b00, 0, 1, q[0], 0, 0);
        nr = 14;
        for (int i = 0; i < 10; i++) cyc(2'b01, nr, 1, q[0], 0, 0);
        cyc(2'b00, 0, 0, 0, 0, 0);
        chk("wrap_no_err", recov_err, 0);

        // Random legal traffic
        for (int i = 0; i < 300; i++) begin
            v   = 2'($urandom);
            r   = 0;
            rid = 0;
            m   = 0;
            mid = 0;
            if (q.size() > 0 && $urandom_range(0, 9) < 4) begin
                r   = 1;
                rid = q[0];
            end
            if ($urandom_range(0, 9) == 0) begin
                lo = r ? 1 : 0;
                if (q.size() > lo) begin
                    m   = 1;
                    mid = q[$urandom_range(lo, q.size() - 1)];
                end
            end
            cyc(v, nr, r, rid, m, mid);
        end

        // Mispredicts during RESTORE/DRAIN are ignored
        for (int i = 0; i < 10; i++) begin
            if (q.size() < 2 || rec_left > 0) cyc(2'b11, nr, 0, 0, 0, 0);
        end
        cyc(2'b00, 0, 0, 0, 1, q[q.size() - 1]);
        cyc(2'b00, 0, 0, 0, 1, q[0]);
        cyc(2'b00, 0, 0, 0, 1, q[0]);
        cyc(2'b00, 0, 0, 0, 1, q[0]);
        cyc(2'b00, 0, 0, 0, 0, 0);
        cyc(2'b00, 0, 0, 0, 0, 0);
        chk("drain_ignore_err", recov_err, 0);

        // Mispredict of an absent robid -> sticky error, no restore
        miss  = 20;
        found = 1;
        for (int t = 0; t < 32 && found; t++) begin
            found = 0;
            foreach (q[i]) if (q[i] == miss) found = 1;
            if (found) miss = (miss + 1) % 32;
        end
        cyc(2'b00, 0, 0, 0, 1, miss);
        cyc(2'b00, 0, 0, 0, 0, 0);
        chk("miss_err", recov_err, 1);
        cyc(2'b00, 0, 0, 0, 0, 0);

        // Retire of the mispredicted head slot: retire wins
        if (q.size() == 0) cyc(2'b01, nr, 0, 0, 0, 0);
        cyc(2'b00, 0, 1, q[0], 1, q[0]);
        cyc(2'b00, 0, 0, 0, 0, 0);

        // Reset in the middle of recovery
        if (q.size() == 0) cyc(2'b01, nr, 0, 0, 0, 0);
        cyc(2'b00, 0, 0, 0, 1, q[0]);
        do_reset();
        cyc(2'b00, 0, 0, 0, 0, 0);
        chk("rst_recov_stall", rename_stall, 0);
        cyc(2'b11, 3, 0, 0, 0, 0);
        cyc(2'b00, 0, 1, 3, 0, 0);
        cyc(2'b00, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
